shift_issue_stage: RTL and testbench

//  ID->EX issue register for the ALU shift path (SLL/SRL/SRA). Selects the shift

---
 rtl/shift_issue_if.sv | 57 +++++
 rtl/shift_issue_stage.sv | 180 ++++++++++++++++++
 tb/tb_shift_issue_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_issue_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_issue_if
//  Description : Handshake and operand bundle between the ID stage, the
//                shift issue register and the EX shifters.
//                slave  : seen from shift_issue_stage
//                master : seen from the driver of the issue stage (ID/EX/WB)
//  Signals     : i_flush, i_in_valid/o_in_ready, i_op, i_use_imm,
//                i_imm_shamt, i_rs1/2_addr, i_rs1/2_data, i_rd_addr,
//                i_ex_wen/rd/data, i_wb_wen/rd/data, o_out_valid/i_out_ready,
//                o_a, o_shamt, o_op, o_rd_addr
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_issue_if #(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_in_valid;
    logic            o_in_ready;
    logic [1:0]      i_op;
    logic            i_use_imm;
    logic [4:0]      i_imm_shamt;
    logic [4:0]      i_rs1_addr;
    logic [4:0]      i_rs2_addr;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [4:0]      i_rd_addr;
    logic            i_ex_wen;
    logic [4:0]      i_ex_rd;
    logic [XLEN-1:0] i_ex_data;
    logic            i_wb_wen;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_data;
    logic            o_out_valid;
    logic            i_out_ready;
    logic [XLEN-1:0] o_a;
    logic [4:0]      o_shamt;
    logic [1:0]      o_op;
    logic [4:0]      o_rd_addr;

    modport slave (
        input  i_flush, i_in_valid, i_op, i_use_imm, i_imm_shamt,
               i_rs1_addr, i_rs2_addr, i_rs1_data, i_rs2_data, i_rd_addr,
               i_ex_wen, i_ex_rd, i_ex_data, i_wb_wen, i_wb_rd, i_wb_data,
               i_out_ready,
        output o_in_ready, o_out_valid, o_a, o_shamt, o_op, o_rd_addr
    );

    modport master (
        output i_flush, i_in_valid, i_op, i_use_imm, i_imm_shamt,
               i_rs1_addr, i_rs2_addr, i_rs1_data, i_rs2_data, i_rd_addr,
               i_ex_wen, i_ex_rd, i_ex_data, i_wb_wen, i_wb_rd, i_wb_data,
               i_out_ready,
        input  o_in_ready, o_out_valid, o_a, o_shamt, o_op, o_rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/shift_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_issue_stage
//  Description : ID->EX issue register for the SLL/SRL/SRA path. Resolves rs1
//                and the shift amount (rs2[4:0] or I-type shamt) with EX/WB
//                bypass at accept time and holds up to two ops in a
//                main + skid register pair so a stalled EX neither loses nor
//                duplicates an op.
//  Ports       : i_clk  - clock, rising edge
//                i_rst  - synchronous reset, active-high
//                bus    - shift_issue_if.slave (upstream handshake, operands,
//                         bypass buses, downstream handshake and operands)
//  Parameters  : XLEN   - operand width (shamt fixed at 5 bits)
//                FWD_EN - 1 enables EX/WB bypass on rs1/rs2
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_issue_stage #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    shift_issue_if.slave    bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_main_a;
    logic [4:0]      r_main_shamt;
    logic [1:0]      r_main_op;
    logic [4:0]      r_main_rd;
    logic [XLEN-1:0] r_skid_a;
    logic [4:0]      r_skid_shamt;
    logic [1:0]      r_skid_op;
    logic [4:0]      r_skid_rd;

    logic            w_accept;
    logic            w_out_fire;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_skid_to_main;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic [4:0]      w_shamt;
    logic            w_unused_rs2_hi;

    // Bypass select: x0 is hard zero, then youngest producer (EX) wins over WB.
    function automatic logic [XLEN-1:0] f_fwd(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_wen,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            wb_wen,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] v;
        v = rf_data;
        if (addr == 5'd0)
            v = '0;
        else if (FWD_EN && ex_wen && (ex_rd == addr))
            v = ex_data;
        else if (FWD_EN && wb_wen && (wb_rd == addr))
            v = wb_data;
        return v;
    endfunction

    always_comb begin
        w_rs1 = f_fwd(bus.i_rs1_addr, bus.i_rs1_data,
                      bus.i_ex_wen, bus.i_ex_rd, bus.i_ex_data,
                      bus.i_wb_wen, bus.i_wb_rd, bus.i_wb_data);
        w_rs2 = f_fwd(bus.i_rs2_addr, bus.i_rs2_data,
                      bus.i_ex_wen, bus.i_ex_rd, bus.i_ex_data,
                      bus.i_wb_wen, bus.i_wb_rd, bus.i_wb_data);
    end

    // Only the low five bits of rs2 form a shift amount.
    assign w_shamt         = bus.i_use_imm ? bus.i_imm_shamt : w_rs2[4:0];
    assign w_unused_rs2_hi = ^w_rs2[XLEN-1:5];

    // Ready/valid come straight from the state register, so o_in_ready has
    // no combinational path from i_out_ready.
    assign bus.o_in_ready  = (r_state != S_FULL);
    assign bus.o_out_valid = (r_state != S_EMPTY);
    assign w_accept        = bus.i_in_valid & bus.o_in_ready;
    assign w_out_fire      = bus.o_out_valid & bus.i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && !w_out_fire) begin
                    w_state_nxt = S_FULL;
                    w_load_skid = 1'b1;
                end else if (!w_accept && w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_accept && w_out_fire) begin
                    w_load_main = 1'b1;
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt    = S_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush kills everything held plus any op offered this cycle; data
        // registers are left stale since valid is dropped.
        if (bus.i_flush) begin
            w_state_nxt    = S_EMPTY;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_a     <= '0;
            r_main_shamt <= '0;
            r_main_op    <= '0;
            r_main_rd    <= '0;
            r_skid_a     <= '0;
            r_skid_shamt <= '0;
            r_skid_op    <= '0;
            r_skid_rd    <= '0;
        end else begin
            if (w_load_main) begin
                r_main_a     <= w_rs1;
                r_main_shamt <= w_shamt;
                r_main_op    <= bus.i_op;
                r_main_rd    <= bus.i_rd_addr;
            end else if (w_skid_to_main) begin
                r_main_a     <= r_skid_a;
                r_main_shamt <= r_skid_shamt;
                r_main_op    <= r_skid_op;
                r_main_rd    <= r_skid_rd;
            end
            if (w_load_skid) begin
                r_skid_a     <= w_rs1;
                r_skid_shamt <= w_shamt;
                r_skid_op    <= bus.i_op;
                r_skid_rd    <= bus.i_rd_addr;
            end
        end
    end

    assign bus.o_a       = r_main_a;
    assign bus.o_shamt   = r_main_shamt;
    assign bus.o_op      = r_main_op;
    assign bus.o_rd_addr = r_main_rd;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_issue_stage
//  Description : Self-checking bench for shift_issue_stage. A queue of
//                expected ops (at most two deep) models the stage; each op's
//                operands are computed from the bypass rules when it is
//                offered and accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [4:0]  rd;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst;
    int     checks = 0;
    int     errors = 0;
    entry_t q[$];

    shift_issue_if #(.XLEN(32)) bus ();

    shift_issue_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_src(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 0) return 32'h0;
        if (bus.i_ex_wen && bus.i_ex_rd == addr) return bus.i_ex_data;
        if (bus.i_wb_wen && bus.i_wb_rd == addr) return bus.i_wb_data;
        return rf;
    endfunction

    function automatic entry_t ref_entry();
        entry_t      e;
        logic [31:0] r2;
        r2      = ref_src(bus.i_rs2_addr, bus.i_rs2_data);
        e.a     = ref_src(bus.i_rs1_addr, bus.i_rs1_data);
        e.shamt = bus.i_use_imm ? bus.i_imm_shamt : r2[4:0];
        e.op    = bus.i_op;
        e.rd    = bus.i_rd_addr;
        return e;
    endfunction

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        bit     acc, fire;
        entry_t e;
        acc  = bus.i_in_valid && (q.size() < 2);
        fire = (q.size() > 0) && bus.i_out_ready;
        e    = ref_entry();
        @(posedge clk);
        if (rst || bus.i_flush) begin
            q.delete();
        end else begin
            if (fire) void'(q.pop_front());
            if (acc)  q.push_back(e);
        end
        #1;
    endtask

    task automatic idle();
        bus.i_flush     = 0; bus.i_in_valid = 0; bus.i_op = 0; bus.i_use_imm = 0;
        bus.i_imm_shamt = 0; bus.i_rs1_addr = 0; bus.i_rs2_addr = 0;
        bus.i_rs1_data  = 0; bus.i_rs2_data = 0; bus.i_rd_addr = 0;
        bus.i_ex_wen    = 0; bus.i_ex_rd = 0; bus.i_ex_data = 0;
        bus.i_wb_wen    = 0; bus.i_wb_rd = 0; bus.i_wb_data = 0;
        bus.i_out_ready = 1;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rd);
        bus.i_in_valid = 1; bus.i_op = 2'b01; bus.i_use_imm = 1; bus.i_imm_shamt = 5'd3;
        bus.i_rs1_addr = rs1; bus.i_rs1_data = d1; bus.i_rd_addr = rd;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
        checks++;
        if ({bus.o_out_valid, bus.o_in_ready} !== 2'b01) begin
            errors++; $display("FAIL reset_hs got v/r=%b%b need 01", bus.o_out_valid, bus.o_in_ready);
        end
        checks++;
        if ({bus.o_a, bus.o_shamt, bus.o_op, bus.o_rd_addr} !== 44'h0) begin
            errors++; $display("FAIL reset_data got a=%h sh=%0d op=%0d rd=%0d need 0",
                               bus.o_a, bus.o_shamt, bus.o_op, bus.o_rd_addr);
        end
    endtask

    task automatic test_srai();
        idle();
        bus.i_in_valid = 1; bus.i_op = 2'b10; bus.i_use_imm = 1; bus.i_imm_shamt = 5'd4;
        bus.i_rs1_addr = 5'd5; bus.i_rs1_data = 32'h8000_0000; bus.i_rd_addr = 5'd9;
        bus.i_rs2_addr = 5'd6; bus.i_rs2_data = 32'h1F;
        tick(); idle();
        checks++;
        if ({bus.o_out_valid, bus.o_a, bus.o_shamt, bus.o_op} !== {1'b1, 32'h8000_0000, 5'd4, 2'b10}) begin
            errors++; $display("FAIL srai got v=%b a=%h sh=%0d op=%b need 1 80000000 4 10",
                               bus.o_out_valid, bus.o_a, bus.o_shamt, bus.o_op);
        end
        tick();
        checks++;
        if (bus.o_out_valid !== 1'b0) begin
            errors++; $display("FAIL srai_drain got v=%b need 0", bus.o_out_valid);
        end
    endtask

    task automatic test_ex_shamt();
        idle();
        bus.i_in_valid = 1; bus.i_op = 2'b10; bus.i_use_imm = 0; bus.i_imm_shamt = 5'd9;
        bus.i_rs2_addr = 5'd7; bus.i_rs2_data = 32'hFFFF_FFE3;
        bus.i_ex_wen = 1; bus.i_ex_rd = 5'd7; bus.i_ex_data = 32'h25;
        tick(); idle();
        checks++;
        if ({bus.o_out_valid, bus.o_shamt} !== {1'b1, 5'd5}) begin
            errors++; $display("FAIL ex_shamt got v=%b sh=%0d need 1 5", bus.o_out_valid, bus.o_shamt);
        end
        tick();
    endtask

    task automatic test_fwd_priority();
        logic [31:0] exp_a [3];
        exp_a = '{32'h11, 32'h22, 32'h0};
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.i_in_valid = 1; bus.i_rs1_addr = (i == 2) ? 5'd0 : 5'd3;
            bus.i_rs1_data = 32'hDEAD_BEEF;
            bus.i_ex_wen = (i != 1); bus.i_ex_rd = bus.i_rs1_addr; bus.i_ex_data = (i == 2) ? 32'h55 : 32'h11;
            bus.i_wb_wen = 1;        bus.i_wb_rd = bus.i_rs1_addr; bus.i_wb_data = 32'h22;
            tick();
            checks++;
            if ({bus.o_out_valid, bus.o_a} !== {1'b1, exp_a[i]}) begin
                errors++; $display("FAIL fwd_prio[%0d] got v=%b a=%h need 1 %h", i, bus.o_out_valid, bus.o_a, exp_a[i]);
            end
        end
        idle(); tick();
    endtask

    task automatic test_back_to_back();
        idle(); bus.i_out_ready = 0;
        offer(5'd1, 32'hA, 5'd1); tick();
        offer(5'd2, 32'hB, 5'd2); tick();
        checks++;
        if ({bus.o_in_ready, bus.o_out_valid, bus.o_a} !== {2'b01, 32'hA}) begin
            errors++; $display("FAIL bp_full got r=%b v=%b a=%h need 0 1 a", bus.o_in_ready, bus.o_out_valid, bus.o_a);
        end
        offer(5'd3, 32'hC, 5'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.o_in_ready, bus.o_a, bus.o_rd_addr} !== {1'b0, 32'hA, 5'd1}) begin
                errors++; $display("FAIL bp_hold[%0d] got r=%b a=%h rd=%0d need 0 a 1", i, bus.o_in_ready, bus.o_a, bus.o_rd_addr);
            end
        end
        idle(); tick();
        checks++;
        if ({bus.o_out_valid, bus.o_a, bus.o_rd_addr} !== {1'b1, 32'hB, 5'd2}) begin
            errors++; $display("FAIL bp_second got v=%b a=%h rd=%0d need 1 b 2", bus.o_out_valid, bus.o_a, bus.o_rd_addr);
        end
        tick();
        checks++;
        if ({bus.o_out_valid, bus.o_in_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_empty got v/r=%b%b need 01", bus.o_out_valid, bus.o_in_ready);
        end
    endtask

    task automatic test_flush();
        // Flush while FULL with upstream still offering.
        idle(); bus.i_out_ready = 0;
        offer(5'd1, 32'h1, 5'd1); tick();
        offer(5'd2, 32'h2, 5'd2); tick();
        offer(5'd3, 32'h3, 5'd3); bus.i_flush = 1; bus.i_out_ready = 1; tick();
        bus.i_flush = 0; bus.i_in_valid = 0;
        checks++;
        if ({bus.o_out_valid, bus.o_in_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_full got v/r=%b%b need 01", bus.o_out_valid, bus.o_in_ready);
        end
        tick();
        checks++;
        if (bus.o_out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_gone got v=%b need 0", bus.o_out_valid);
        end
        // Flush while ONE: the op that would have been accepted is dropped.
        bus.i_out_ready = 0; offer(5'd4, 32'h4, 5'd4); tick();
        offer(5'd5, 32'h5, 5'd5); bus.i_flush = 1; tick();
        idle();
        checks++;
        if (bus.o_out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_one got v=%b need 0", bus.o_out_valid);
        end
    endtask

    task automatic test_reset_mid_full();
        idle(); bus.i_out_ready = 0;
        offer(5'd1, 32'h77, 5'd1); tick();
        offer(5'd2, 32'h88, 5'd2); tick();
        rst = 1; bus.i_out_ready = 1; tick(); rst = 0; idle();
        checks++;
        if ({bus.o_out_valid, bus.o_in_ready, bus.o_a} !== {2'b01, 32'h0}) begin
            errors++; $display("FAIL rst_full got v=%b r=%b a=%h need 0 1 0", bus.o_out_valid, bus.o_in_ready, bus.o_a);
        end
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 600; n++) begin
            bus.i_flush     = ($urandom_range(0, 31) == 0);
            bus.i_in_valid  = ($urandom_range(0, 9) < 6);
            bus.i_out_ready = ($urandom_range(0, 9) < 5);
            bus.i_op        = 2'($urandom_range(0, 3));
            bus.i_use_imm   = $urandom_range(0, 1) == 1;
            bus.i_imm_shamt = 5'($urandom);
            bus.i_rs1_addr  = 5'($urandom_range(0, 3));
            bus.i_rs2_addr  = 5'($urandom_range(0, 3));
            bus.i_rs1_data  = $urandom; bus.i_rs2_data = $urandom;
            bus.i_rd_addr   = 5'($urandom);
            bus.i_ex_wen    = $urandom_range(0, 1) == 1; bus.i_ex_rd = 5'($urandom_range(0, 3));
            bus.i_ex_data   = $urandom;
            bus.i_wb_wen    = $urandom_range(0, 1) == 1; bus.i_wb_rd = 5'($urandom_range(0, 3));
            bus.i_wb_data   = $urandom;
            tick();
            checks++;
            if ({bus.o_out_valid, bus.o_in_ready} !== {q.size() > 0, q.size() < 2}) begin
                errors++; $display("FAIL rand_hs[%0d] got v/r=%b%b need %b%b", n,
                                   bus.o_out_valid, bus.o_in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                checks++;
                if ({bus.o_a, bus.o_shamt, bus.o_op, bus.o_rd_addr} !== q[0]) begin
                    errors++; $display("FAIL rand_data[%0d] got a=%h sh=%0d op=%0d rd=%0d need a=%h sh=%0d op=%0d rd=%0d",
                                       n, bus.o_a, bus.o_shamt, bus.o_op, bus.o_rd_addr,
                                       q[0].a, q[0].shamt, q[0].op, q[0].rd);
                end
            end
        end
        idle();
    endtask

    initial begin
        rst = 1;
        test_reset();
        test_srai();
        test_ex_shamt();
        test_fwd_priority();
        test_back_to_back();
        test_flush();
        test_reset_mid_full();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
